// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: requester handshake and external SRAM pins
// for the three-port round-robin SRAM arbiter.
interface sram_port_arbiter_if;
  logic [2:0]  req;
  logic [9:0]  req_addr0;
  logic [9:0]  req_addr1;
  logic [9:0]  req_addr2;
  logic [63:0] req_wdata2;
  logic [2:0]  grant;
  logic [2:0]  done;
  logic [2:0]  err;
  logic [63:0] rd_data;
  logic        wen;
  logic        ren;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [1:0]  sram_state;

  modport slave (
    input  req,
    input  req_addr0,
    input  req_addr1,
    input  req_addr2,
    input  req_wdata2,
    input  rdata,
    input  sram_state,
    output grant,
    output done,
    output err,
    output rd_data,
    output wen,
    output ren,
    output addr,
    output wdata
  );

  modport master (
    output req,
    output req_addr0,
    output req_addr1,
    output req_addr2,
    output req_wdata2,
    output rdata,
    output sram_state,
    input  grant,
    input  done,
    input  err,
    input  rd_data,
    input  wen,
    input  ren,
    input  addr,
    input  wdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin share of one 32-bit SRAM port
// between three 64-bit requesters, each split into two halves.
module sram_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic               clk,
  input logic               n_rst,
  sram_port_arbiter_if.slave bus
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  localparam logic [1:0] SS_FREE   = 2'd0;
  localparam logic [1:0] SS_ACCESS = 2'd2;
  localparam logic [1:0] SS_ERROR  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_LO,
    WAIT_LO,
    ISSUE_HI,
    WAIT_HI,
    FIN
  } state_t;

  state_t state;
  state_t nxt;

  logic [1:0]    rr;
  logic [1:0]    sel;
  logic [9:0]    addr_q;
  logic [63:0]   wbuf;
  logic          err_q;
  logic [CW-1:0] cnt;

  logic [1:0]  pick;
  logic [1:0]  p1;
  logic [1:0]  p2;
  logic [9:0]  pick_addr;
  logic        any_req;
  logic        is_wr;
  logic        issue_st;
  logic        wait_st;
  logic        sfree;
  logic        sacc;
  logic        serr;
  logic        tmo;
  logic        abort;

  logic [2:0]  grant_d;
  logic [2:0]  done_d;
  logic [2:0]  err_d;
  logic        wen_d;
  logic        ren_d;
  logic [9:0]  addr_d;
  logic [31:0] wdata_d;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // Round-robin pick: first requester at or after rr, mod 3
  always_comb begin
    p1 = inc3(rr);
    p2 = inc3(p1);
    pick = p2;
    if (bus.req[p1]) pick = p1;
    if (bus.req[rr]) pick = rr;
    any_req = |bus.req;
    case (pick)
      2'd0:    pick_addr = bus.req_addr0;
      2'd1:    pick_addr = bus.req_addr1;
      default: pick_addr = bus.req_addr2;
    endcase
  end

  // SRAM status decode and abort (error or timeout) detection
  always_comb begin
    is_wr    = (sel == 2'd2);
    issue_st = (state == ISSUE_LO) || (state == ISSUE_HI);
    wait_st  = (state == WAIT_LO) || (state == WAIT_HI);
    sfree    = (bus.sram_state == SS_FREE);
    sacc     = (bus.sram_state == SS_ACCESS);
    serr     = (bus.sram_state == SS_ERROR);
    tmo      = (cnt == TMAX);
    abort    = (wait_st && !sacc && (serr || tmo))
            || (issue_st && !sfree && tmo);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!n_rst) state <= IDLE;
    else        state <= nxt;
  end

  // FSM next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:     if (any_req) nxt = ISSUE_LO;
      ISSUE_LO: begin
        if (sfree)      nxt = WAIT_LO;
        else if (abort) nxt = FIN;
      end
      WAIT_LO:  begin
        if (sacc)       nxt = ISSUE_HI;
        else if (abort) nxt = FIN;
      end
      ISSUE_HI: begin
        if (sfree)      nxt = WAIT_HI;
        else if (abort) nxt = FIN;
      end
      WAIT_HI:  if (sacc || abort) nxt = FIN;
      FIN:      nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  // FSM output logic: next values of the registered outputs
  always_comb begin
    grant_d = bus.grant;
    done_d  = 3'b000;
    err_d   = 3'b000;
    wen_d   = 1'b0;
    ren_d   = 1'b0;
    addr_d  = bus.addr;
    wdata_d = bus.wdata;
    unique case (state)
      IDLE: begin
        if (any_req) grant_d = 3'b001 << pick;
      end
      ISSUE_LO: begin
        if (sfree) begin
          wen_d  = is_wr;
          ren_d  = !is_wr;
          addr_d = addr_q;
          if (is_wr) wdata_d = wbuf[31:0];
        end
      end
      ISSUE_HI: begin
        if (sfree) begin
          wen_d  = is_wr;
          ren_d  = !is_wr;
          addr_d = addr_q + 10'd1;
          if (is_wr) wdata_d = wbuf[63:32];
        end
      end
      FIN: begin
        done_d  = err_q ? 3'b000 : bus.grant;
        err_d   = err_q ? bus.grant : 3'b000;
        grant_d = 3'b000;
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      bus.grant <= 3'b000;
      bus.done  <= 3'b000;
      bus.err   <= 3'b000;
      bus.wen   <= 1'b0;
      bus.ren   <= 1'b0;
      bus.addr  <= 10'd0;
      bus.wdata <= 32'd0;
    end else begin
      bus.grant <= grant_d;
      bus.done  <= done_d;
      bus.err   <= err_d;
      bus.wen   <= wen_d;
      bus.ren   <= ren_d;
      bus.addr  <= addr_d;
      bus.wdata <= wdata_d;
    end
  end

  // Request latch, read capture, error flag, wait counter, rr pointer
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rr          <= 2'd0;
      sel         <= 2'd0;
      addr_q      <= 10'd0;
      wbuf        <= 64'd0;
      err_q       <= 1'b0;
      cnt         <= '0;
      bus.rd_data <= 64'd0;
    end else begin
      if (state == IDLE && any_req) begin
        sel    <= pick;
        addr_q <= pick_addr;
        wbuf   <= (pick == 2'd2) ? bus.req_wdata2 : 64'd0;
      end
      if (nxt != state)
        cnt <= '0;
      else if (issue_st || wait_st)
        cnt <= cnt + CW'(1);
      if (state == WAIT_LO && sacc && !is_wr)
        bus.rd_data[31:0] <= bus.rdata;
      if (state == WAIT_HI && sacc && !is_wr)
        bus.rd_data[63:32] <= bus.rdata;
      if (state == FIN)
        err_q <= 1'b0;
      else if (abort)
        err_q <= 1'b1;
      if (state == FIN)
        rr <= inc3(sel);
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: scoreboard bench with a behavioural SRAM,
// directed requests and hand-computed strobes and responses.
module tb_sram_port_arbiter;

  logic clk = 1'b0;
  logic n_rst;

  sram_port_arbiter_if bus ();

  sram_port_arbiter #(
    .TIMEOUT(8)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         w;
    logic [9:0] a;
    logic [31:0] d;
    logic [2:0] g;
  } strb_t;

  typedef struct {
    logic [2:0]  dn;
    logic [2:0]  er;
    logic [63:0] rd;
    bit          chk;
    int          cyc;
  } resp_t;

  strb_t exp_strb[$];
  resp_t exp_resp[$];

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [31:0] mem [0:1023];
  int busy_left = 0;
  bit stuck = 1'b0;
  bit err_inj = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: answers a strobe with ACCESS (or ERROR) next sample
  always @(posedge clk) begin
    #1;
    if (bus.ren || bus.wen) begin
      if (bus.wen) mem[bus.addr] = bus.wdata;
      else         bus.rdata = mem[bus.addr];
      if (err_inj) begin
        bus.sram_state = 2'd3;
        err_inj = 1'b0;
      end else begin
        bus.sram_state = 2'd2;
      end
    end else if (stuck) begin
      bus.sram_state = 2'd1;
    end else if (busy_left > 0) begin
      busy_left = busy_left - 1;
      bus.sram_state = 2'd1;
    end else begin
      bus.sram_state = 2'd0;
    end
  end

  // Monitor: pops expectations whenever a strobe or done/err appears
  bit prev_strb = 1'b0;
  always @(negedge clk) begin
    strb_t es;
    resp_t er;
    if (bus.ren || bus.wen) begin
      n_vec++;
      if (exp_strb.size() == 0) begin
        n_bad++;
        $display("FAIL strobe: unexpected wen=%b ren=%b addr=%h",
                 bus.wen, bus.ren, bus.addr);
      end else begin
        es = exp_strb.pop_front();
        if (bus.wen !== es.w || bus.ren !== !es.w ||
            bus.addr !== es.a || (es.w && bus.wdata !== es.d) ||
            bus.grant !== es.g || prev_strb) begin
          n_bad++;
          $display({"FAIL strobe: got wen=%b ren=%b addr=%h wdata=%h",
                    " grant=%b b2b=%b, want w=%b addr=%h wdata=%h grant=%b"},
                   bus.wen, bus.ren, bus.addr, bus.wdata, bus.grant,
                   prev_strb, es.w, es.a, es.d, es.g);
        end
      end
    end
    prev_strb = bus.ren || bus.wen;
    if (|bus.done || |bus.err) begin
      n_vec++;
      if (exp_resp.size() == 0) begin
        n_bad++;
        $display("FAIL resp: unexpected done=%b err=%b cyc=%0d",
                 bus.done, bus.err, cyc);
      end else begin
        er = exp_resp.pop_front();
        if (bus.done !== er.dn || bus.err !== er.er ||
            (er.chk && bus.rd_data !== er.rd) || cyc != er.cyc) begin
          n_bad++;
          $display({"FAIL resp: got done=%b err=%b rd=%h cyc=%0d,",
                    " want done=%b err=%b rd=%h cyc=%0d"},
                   bus.done, bus.err, bus.rd_data, cyc,
                   er.dn, er.er, er.rd, er.cyc);
        end
      end
    end
  end

  task automatic exp_read(input logic [9:0] a, input logic [2:0] g,
                          input logic [63:0] rd, input int c);
    exp_strb.push_back('{1'b0, a, 32'h0, g});
    exp_strb.push_back('{1'b0, a + 10'd1, 32'h0, g});
    exp_resp.push_back('{g, 3'b000, rd, 1'b1, c});
  endtask

  task automatic exp_write(input logic [9:0] a, input logic [63:0] d,
                           input int c);
    exp_strb.push_back('{1'b1, a, d[31:0], 3'b100});
    exp_strb.push_back('{1'b1, a + 10'd1, d[63:32], 3'b100});
    exp_resp.push_back('{3'b100, 3'b000, 64'h0, 1'b0, c});
  endtask

  task automatic wait_evt(input string what);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (|bus.done || |bus.err) return;
    end
    n_vec++;
    n_bad++;
    $display("FAIL %s: no done/err within 40 cycles", what);
  endtask

  task automatic chk_zero(input string what);
    n_vec++;
    if ({bus.grant, bus.done, bus.err, bus.wen, bus.ren,
         bus.addr, bus.wdata, bus.rd_data} !== '0) begin
      n_bad++;
      $display({"FAIL %s: got grant=%b done=%b err=%b wen=%b ren=%b",
                " addr=%h wdata=%h rd=%h, want all zero"},
               what, bus.grant, bus.done, bus.err, bus.wen, bus.ren,
               bus.addr, bus.wdata, bus.rd_data);
    end
  endtask

  int s;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[10'h010] = 32'hAAAA0001;
    mem[10'h011] = 32'hBBBB0002;
    mem[10'h100] = 32'h10001000;
    mem[10'h101] = 32'h10011001;
    mem[10'h200] = 32'h20002000;
    mem[10'h201] = 32'h20012001;
    bus.req = 3'b000;
    bus.req_addr0 = 10'h0;
    bus.req_addr1 = 10'h0;
    bus.req_addr2 = 10'h0;
    bus.req_wdata2 = 64'h0;
    bus.rdata = 32'h0;
    bus.sram_state = 2'd0;
    n_rst = 1'b0;

    repeat (2) @(negedge clk);
    chk_zero("reset");
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // single read on port 0
    s = cyc;
    exp_strb.push_back('{1'b0, 10'h010, 32'h0, 3'b001});
    exp_strb.push_back('{1'b0, 10'h011, 32'h0, 3'b001});
    exp_resp.push_back('{3'b001, 3'b000, 64'hBBBB0002_AAAA0001, 1'b1, s + 6});
    bus.req_addr0 = 10'h010;
    bus.req = 3'b001;
    wait_evt("read");
    bus.req = 3'b000;
    repeat (2) @(negedge clk);

    // write on port 2 across the address wrap
    s = cyc;
    exp_strb.push_back('{1'b1, 10'h3FF, 32'h55667788, 3'b100});
    exp_strb.push_back('{1'b1, 10'h000, 32'h11223344, 3'b100});
    exp_resp.push_back('{3'b100, 3'b000, 64'h0, 1'b0, s + 6});
    bus.req_addr2 = 10'h3FF;
    bus.req_wdata2 = 64'h11223344_55667788;
    bus.req = 3'b100;
    wait_evt("write");
    bus.req = 3'b000;
    repeat (2) @(negedge clk);

    // round robin, all ports requesting continuously
    s = cyc;
    bus.req_addr0 = 10'h100;
    bus.req_addr1 = 10'h200;
    bus.req_addr2 = 10'h300;
    bus.req_wdata2 = 64'hCAFEF00D_DEADBEEF;
    for (int k = 0; k < 9; k++) begin
      case (k % 3)
        0: exp_read(10'h100, 3'b001, 64'h10011001_10001000, s + 6 * (k + 1));
        1: exp_read(10'h200, 3'b010, 64'h20012001_20002000, s + 6 * (k + 1));
        default: exp_write(10'h300, 64'hCAFEF00D_DEADBEEF, s + 6 * (k + 1));
      endcase
    end
    bus.req = 3'b111;
    for (int k = 0; k < 9; k++) wait_evt("round_robin");
    bus.req = 3'b000;
    repeat (2) @(negedge clk);

    // SRAM busy for 4 cycles before the low half is accepted
    s = cyc;
    bus.req_addr0 = 10'h010;
    exp_read(10'h010, 3'b001, 64'hBBBB0002_AAAA0001, s + 10);
    busy_left = 4;
    bus.req = 3'b001;
    wait_evt("stall");
    bus.req = 3'b000;
    repeat (2) @(negedge clk);

    // ERROR during the low half on port 1: no high-half strobe
    s = cyc;
    bus.req_addr1 = 10'h200;
    exp_strb.push_back('{1'b0, 10'h200, 32'h0, 3'b010});
    exp_resp.push_back('{3'b000, 3'b010, 64'h0, 1'b0, s + 4});
    err_inj = 1'b1;
    bus.req = 3'b010;
    wait_evt("sram_error");
    bus.req = 3'b000;
    repeat (4) @(negedge clk);

    // timeout on port 2 with SRAM stuck busy, then port 0 served
    s = cyc;
    exp_resp.push_back('{3'b000, 3'b100, 64'h0, 1'b0, s + 10});
    exp_read(10'h010, 3'b001, 64'hBBBB0002_AAAA0001, s + 16);
    stuck = 1'b1;
    bus.req = 3'b101;
    wait_evt("timeout");
    bus.req = 3'b001;
    stuck = 1'b0;
    wait_evt("after_timeout");
    bus.req = 3'b000;
    repeat (2) @(negedge clk);

    // reset during WAIT_HI on port 1, then fresh start from port 0
    s = cyc;
    exp_strb.push_back('{1'b0, 10'h200, 32'h0, 3'b010});
    exp_strb.push_back('{1'b0, 10'h201, 32'h0, 3'b010});
    bus.req = 3'b010;
    repeat (4) @(negedge clk);
    n_rst = 1'b0;
    bus.req = 3'b000;
    @(negedge clk);
    chk_zero("mid_reset");
    @(negedge clk);
    n_rst = 1'b1;
    s = cyc;
    bus.req_addr0 = 10'h100;
    exp_read(10'h100, 3'b001, 64'h10011001_10001000, s + 6);
    exp_read(10'h200, 3'b010, 64'h20012001_20002000, s + 12);
    bus.req = 3'b011;
    wait_evt("post_reset_p0");
    bus.req = 3'b010;
    wait_evt("post_reset_p1");
    bus.req = 3'b000;
    repeat (4) @(negedge clk);

    n_vec++;
    if (exp_strb.size() != 0 || exp_resp.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d strobes %0d resps pending, want 0 0",
               exp_strb.size(), exp_resp.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares the accelerator's single 32-bit external SRAM port between three 64-bit requesters: weight fetch, input fetch and output writeback. Arbitration is round-robin. Each 64-bit request is split into two 32-bit SRAM transactions, sequenced against the `sram_state` handshake. The block sits between the SRAM buffer logic and the external SRAM pins, and owns `wen`, `ren`, `addr` and `wdata` exclusively.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum cycles spent in one wait state before the request is aborted with an error.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock, all logic on the rising edge.
- `n_rst`  in  1  synchronous active-low reset.
- `req`  in  3  request per port: [0] weight read, [1] input read, [2] output write. Held until `done` or `err` for that port.
- `req_addr0`, `req_addr1`, `req_addr2`  in  10 each  word address of the low half, stable while `req` is high.
- `req_wdata2`  in  64  write data for port 2, stable while `req[2]` is high.
- `grant`  out  3  one-hot, the port currently being served.
- `done`  out  3  one-cycle pulse on the served port when the transfer completes.
- `err`  out  3  one-cycle pulse on the served port when the transfer is aborted.
- `rd_data`  out  64  assembled read data, valid while `done[0]` or `done[1]` is high.
- `wen`, `ren`  out  1 each  SRAM write and read strobes.
- `addr`  out  10  SRAM address.
- `wdata`  out  32  SRAM write data.
- `rdata`  in  32  SRAM read data.
- `sram_state`  in  2  SRAM status: 0 FREE, 1 BUSY, 2 ACCESS (transaction complete, `rdata` valid for reads), 3 ERROR.

## Operation
- FSM states: IDLE, ISSUE_LO, WAIT_LO, ISSUE_HI, WAIT_HI, FIN.
- IDLE:
  - If any `req` bit is set, select the first requesting port starting from the round-robin pointer `rr`, searching upward mod 3.
  - Latch the port index, address and write data; set `grant`; go to ISSUE_LO.
- ISSUE_LO:
  - If `sram_state` is FREE, drive `ren` (ports 0 and 1) or `wen` (port 2) high for exactly this cycle, with `addr` = latched address and `wdata` = data[31:0]. Then go to WAIT_LO.
  - Otherwise stay, with strobes low.
- WAIT_LO:
  - On ACCESS, capture `rdata` into data[31:0] for reads and go to ISSUE_HI.
  - On ERROR, go to FIN with error flagged.
- ISSUE_HI / WAIT_HI: same as the LO states, with `addr` = latched address + 1 (10-bit wrap, so 0x3FF+1 = 0x000), `wdata` = data[63:32], and capture into [63:32].
- FIN:
  - Pulse `done[g]`, or `err[g]` if error is flagged; `rd_data` is presented.
  - Set `rr` = (g+1) mod 3, clear `grant` and the error flag, return to IDLE.
- Timeout: a counter resets on entry to each ISSUE/WAIT state. Reaching `TIMEOUT` cycles in that state sets the error flag and goes to FIN.
- A requester must drop `req` the cycle after `done`/`err`. If it does not, it is re-arbitrated with lowest priority.
- `req` changes during a transfer are ignored until IDLE.

## Timing
- Reset, checked at the clock edge while `n_rst`=0:
  - State IDLE, `rr`=0.
  - `grant`, `done`, `err`, `wen`, `ren` = 0.
  - `addr`=0, `wdata`=0, `rd_data`=0, timeout counter = 0.
  - Reset mid-transfer aborts immediately, with no `done`/`err` pulse.
- All outputs are registered.
- Minimum latency, with SRAM FREE and ACCESS the cycle after each strobe:
  - `req` sampled in IDLE at edge 0.
  - `ren`/`wen` low-half strobe at cycle 1, high-half strobe at cycle 3.
  - `done` at cycle 5.
  - 6 cycles per 64-bit transfer including IDLE.
- Strobes are never high in two consecutive cycles. `wen` and `ren` are never both high.
- The `rd_data` low half is stable from WAIT_LO capture through FIN. After FIN, `rd_data` holds until the next capture.
- An ERROR during the low half skips the high half entirely.

## Test plan
- Single read: `req`=001, `req_addr0`=0x010, SRAM returns 0xAAAA0001 then 0xBBBB0002 → `ren` at 0x010 then 0x011, `done`=001 at cycle 5, `rd_data`=0xBBBB0002AAAA0001.
- Write: `req`=100, `req_wdata2`=0x1122334455667788, `req_addr2`=0x3FF → `wen` with `wdata`=0x55667788 @0x3FF, then `wdata`=0x11223344 @0x000, then `done`=100.
- Round-robin: all three ports requesting continuously from reset → grant order 001, 010, 100, 001, with no starvation over 9 transfers.
- SRAM stalls: `sram_state`=BUSY for 4 cycles before ISSUE_LO is accepted → strobe is delayed until FREE, then a single strobe; `done` arrives at cycle 9.
- Error and timeout:
  - ERROR in WAIT_LO → `err`=010, no high-half strobe.
  - With `TIMEOUT`=8 and SRAM stuck in BUSY → `err` pulses after 8 wait cycles, and the next port is granted.
- Reset mid-transfer: assert `n_rst`=0 during WAIT_HI → next cycle all outputs are 0, no `done`; after release, a fresh request completes normally starting from port 0.
